cpu_fetch_decode: RTL and testbench
===================================

CPU_FETCH_DECODE -- requirements
Module: cpu_fetch_decode

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, program address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, decoded-instruction queue depth; power of two, >=2.
REQ-003 SHALL have parameter HLT_STALL, default 1; 1 = stop byte intake after HLT until resumed, 0 = no stall.
REQ-004 CLK_I  in  1  sole clock, rising edge.
REQ-005 RST_N_I  in  1  reset, asynchronous, active-low.
REQ-006 FLUSH_I  in  1  synchronous flush of partial instruction and queue.
REQ-007 RESUME_I  in  1  releases halt stall.
REQ-008 BYTE_I  in  8  instruction byte stream.
REQ-009 BYTE_PC_I  in  ADDR_W  address of BYTE_I.
REQ-010 BYTE_VLD_I  in  1  BYTE_I valid.
REQ-011 BYTE_RDY_O  out  1  block accepts byte; transfer = BYTE_VLD_I & BYTE_RDY_O.
REQ-012 INS_VLD_O  out  1  queue head valid.
REQ-013 INS_RDY_I  in  1  consumer pops head; pop = INS_VLD_O & INS_RDY_I.
REQ-014 INS_CLASS_O  out  5  class code of head.
REQ-015 INS_OP_O  out  8  opcode byte of head.
REQ-016 INS_IMM_O  out  16  byte2 in [7:0], byte3 in [15:8], absent bytes 0.
REQ-017 INS_LEN_O  out  2  instruction length 1..3.
REQ-018 INS_PC_O  out  ADDR_W  address of opcode byte.
REQ-019 FIFO_CNT_O  out  clog2(FIFO_DEPTH)+1  entries held.

Function
REQ-020 Class codes SHALL be (first match wins): 0 NOP 0000000x; 1 HLT 11111111; 2 INC 00DDD000 DDD 1..6; 3 DCR 00DDD001 DDD 1..6; 4 ROT 000xx010; 5 RETC 00CCC011; 6 ALUI 00PPP100; 7 RST 00AAA101; 8 LRI 00DDD110 DDD!=7; 9 LMI 00111110; 10 RET 00xxx111; 11 JMPC 01CCC000; 12 CALC 01CCC010; 13 JMP 01xxx100; 14 CAL 01xxx110; 15 INP 0100MMM1; 16 OUT 01RRMMM1 RR!=00; 17 ALUR 10PPPSSS SSS!=7; 18 ALUM 10PPP111; 19 LRR 11DDDSSS DDD!=7, SSS!=7; 20 LRM 11DDD111 DDD!=7; 21 LMR 11111SSS SSS!=7; 22 ILLEGAL otherwise (001xx010, 00111000, 00111001).
REQ-021 Length SHALL be 2 for ALUI/LRI/LMI, 3 for JMPC/CALC/JMP/CAL, 1 otherwise including ILLEGAL.
REQ-022 FSM states SHALL be S_OP, S_B2, S_B3, S_HALT.
REQ-023 S_OP: accepted byte is opcode, BYTE_PC_I captured; length 1 -> push, stay S_OP (or S_HALT per REQ-026); else -> S_B2.
REQ-024 S_B2: accepted byte -> IMM[7:0]; length 2 -> push, S_OP; length 3 -> S_B3. S_B3: accepted byte -> IMM[15:8], push, S_OP.
REQ-025 BYTE_RDY_O SHALL be 1 only in S_OP/S_B2/S_B3 with queue not full and FLUSH_I low; no push when full.
REQ-026 With HLT_STALL=1, pushing HLT SHALL enter S_HALT; S_HALT holds BYTE_RDY_O=0 until RESUME_I=1, then S_OP next cycle; RESUME_I ignored elsewhere; HLT_STALL=0 stays S_OP.
REQ-027 Latency: last byte accepted at edge N -> INS_VLD_O=1 with that entry after edge N; no combinational bypass.
REQ-028 Queue SHALL be in-order; simultaneous push and pop SHALL both occur, count unchanged; pop when empty impossible (INS_VLD_O=0).
REQ-029 Outputs SHALL be stable while INS_VLD_O=1 and INS_RDY_I=0.
REQ-030 FLUSH_I=1 SHALL, at next edge, empty queue, discard partial instruction and any same-cycle push, state -> S_OP (also from S_HALT); FLUSH_I has priority over RESUME_I.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; FIFO_CNT_O reaches FIFO_DEPTH exactly when full.

Reset
REQ-032 RST_N_I=0 SHALL immediately force state S_OP, queue empty, FIFO_CNT_O=0, INS_VLD_O=0, BYTE_RDY_O=0, INS_* = 0, regardless of clock; mid-instruction bytes discarded.
REQ-033 BYTE_RDY_O SHALL be 1 from first edge after RST_N_I deasserts.

Verification
REQ-034 Bytes 0x44,0x34,0x12 at PCs 0x100..0x102 -> one entry class 13, LEN 3, IMM 0x1234, PC 0x100, VLD one cycle after 0x12.
REQ-035 INS_RDY_I=0, five 1-byte ops 0xC1 (DEPTH 4) -> CNT 4, BYTE_RDY_O=0, fifth held; pop one -> fifth accepted, order preserved.
REQ-036 0xFF then 0xC0 (HLT_STALL=1) -> HLT pushed, BYTE_RDY_O=0; RESUME_I pulse -> 0xC0 accepted as LRR class 19.
REQ-037 0x06, FLUSH_I, 0x3E,0x55 -> 0x06 discarded; single LMI class 9, IMM 0x0055.
REQ-038 Bytes 0x3A, 0x38, 0x00 -> classes 22, 22, 0 each LEN 1; RST_N_I low during 0x46's second byte -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cpu_fetch_decode.sv
// Byte-serial fetch/decode front end: assembles 1..3 byte instructions, classifies
// the opcode and queues decoded entries in an in-order FIFO.
module cpu_fetch_decode #(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int HLT_STALL  = 1
) (
  input  logic                        CLK_I,
  input  logic                        RST_N_I,
  input  logic                        FLUSH_I,
  input  logic                        RESUME_I,
  input  logic [7:0]                  BYTE_I,
  input  logic [ADDR_W-1:0]           BYTE_PC_I,
  input  logic                        BYTE_VLD_I,
  output logic                        BYTE_RDY_O,
  output logic                        INS_VLD_O,
  input  logic                        INS_RDY_I,
  output logic [4:0]                  INS_CLASS_O,
  output logic [7:0]                  INS_OP_O,
  output logic [15:0]                 INS_IMM_O,
  output logic [1:0]                  INS_LEN_O,
  output logic [ADDR_W-1:0]           INS_PC_O,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_CNT_O
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_OP, S_B2, S_B3, S_HALT} state_t;

  typedef struct packed {
    logic [4:0]        cls;
    logic [7:0]        op;
    logic [15:0]       imm;
    logic [1:0]        len;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  function automatic logic [4:0] decode_class(input logic [7:0] op);
    logic [2:0] mid;
    logic [2:0] lo;
    logic [4:0] c;
    mid = op[5:3];
    lo  = op[2:0];
    c   = 5'd22;
    if (op[7:1] == 7'd0) begin
      c = 5'd0;
    end else if (op == 8'hFF) begin
      c = 5'd1;
    end else begin
      case (op[7:6])
        2'b00: begin
          case (lo)
            3'd0:    c = (mid != 3'd7) ? 5'd2 : 5'd22;
            3'd1:    c = (mid != 3'd7) ? 5'd3 : 5'd22;
            3'd2:    c = mid[2] ? 5'd22 : 5'd4;
            3'd3:    c = 5'd5;
            3'd4:    c = 5'd6;
            3'd5:    c = 5'd7;
            3'd6:    c = (mid != 3'd7) ? 5'd8 : 5'd9;
            default: c = 5'd10;
          endcase
        end
        2'b01: begin
          if (lo[0]) begin
            c = (mid[2:1] == 2'b00) ? 5'd15 : 5'd16;
          end else begin
            case (lo[2:1])
              2'd0:    c = 5'd11;
              2'd1:    c = 5'd12;
              2'd2:    c = 5'd13;
              default: c = 5'd14;
            endcase
          end
        end
        2'b10:   c = (lo == 3'd7) ? 5'd18 : 5'd17;
        default: c = (mid == 3'd7) ? 5'd21 : ((lo == 3'd7) ? 5'd20 : 5'd19);
      endcase
    end
    return c;
  endfunction

  function automatic logic [1:0] decode_len(input logic [4:0] cls);
    logic [1:0] l;
    case (cls)
      5'd6, 5'd8, 5'd9:          l = 2'd2;
      5'd11, 5'd12, 5'd13, 5'd14: l = 2'd3;
      default:                   l = 2'd1;
    endcase
    return l;
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        op_q;
  logic [7:0]        imm_lo_q;
  logic [ADDR_W-1:0] pc_q;
  logic              rdy_en_q;
  entry_t            mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;

  logic       full, byte_rdy, accept, pop, push;
  logic [4:0] byte_cls, part_cls;
  logic [1:0] byte_len, part_len;
  entry_t     push_entry, head;

  assign full     = (cnt_q == DEPTH_C);
  assign byte_rdy = rdy_en_q && (state_q != S_HALT) && !full && !FLUSH_I;
  assign accept   = BYTE_VLD_I && byte_rdy;
  assign pop      = (cnt_q != '0) && INS_RDY_I;
  assign byte_cls = decode_class(BYTE_I);
  assign byte_len = decode_len(byte_cls);
  assign part_cls = decode_class(op_q);
  assign part_len = decode_len(part_cls);

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q  <= S_OP;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (FLUSH_I) begin
      state_d = S_OP;
    end else begin
      case (state_q)
        S_OP: if (accept) begin
          if (byte_len != 2'd1)                         state_d = S_B2;
          else if (HLT_STALL != 0 && byte_cls == 5'd1) state_d = S_HALT;
        end
        S_B2:    if (accept) state_d = (part_len == 2'd2) ? S_OP : S_B3;
        S_B3:    if (accept) state_d = S_OP;
        default: if (RESUME_I) state_d = S_OP;
      endcase
    end
  end

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      S_OP: if (accept && byte_len == 2'd1) begin
        push       = 1'b1;
        push_entry = '{byte_cls, BYTE_I, 16'h0000, byte_len, BYTE_PC_I};
      end
      S_B2: if (accept && part_len == 2'd2) begin
        push       = 1'b1;
        push_entry = '{part_cls, op_q, {8'h00, BYTE_I}, part_len, pc_q};
      end
      S_B3: if (accept) begin
        push       = 1'b1;
        push_entry = '{part_cls, op_q, {BYTE_I, imm_lo_q}, part_len, pc_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      op_q     <= '0;
      imm_lo_q <= '0;
      pc_q     <= '0;
    end else begin
      if (state_q == S_OP && accept) begin
        op_q <= BYTE_I;
        pc_q <= BYTE_PC_I;
      end
      if (state_q == S_B2 && accept) imm_lo_q <= BYTE_I;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (FLUSH_I) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  // Storage is not reset; an empty queue forces every INS_* field to zero instead.
  assign head        = (cnt_q != '0) ? mem[rd_ptr_q] : '0;
  assign BYTE_RDY_O  = byte_rdy;
  assign INS_VLD_O   = (cnt_q != '0);
  assign INS_CLASS_O = head.cls;
  assign INS_OP_O    = head.op;
  assign INS_IMM_O   = head.imm;
  assign INS_LEN_O   = head.len;
  assign INS_PC_O    = head.pc;
  assign FIFO_CNT_O  = cnt_q;

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Bench for cpu_fetch_decode: directed scenarios plus randomized traffic against
// a queue-based reference model of the decoder.
module tb_cpu_fetch_decode;

  typedef struct packed {
    logic [4:0]  cls;
    logic [7:0]  op;
    logic [15:0] imm;
    logic [1:0]  len;
    logic [13:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, resume, vld, ins_rdy;
  logic [7:0]  data;
  logic [13:0] pc;
  logic        byte_rdy, ins_vld;
  logic [4:0]  ins_class;
  logic [7:0]  ins_op;
  logic [15:0] ins_imm;
  logic [1:0]  ins_len;
  logic [13:0] ins_pc;
  logic [2:0]  fifo_cnt;

  int checks = 0;
  int failures = 0;

  ent_t       q[$];
  logic [7:0] pend[3];
  logic [13:0] pend_pc;
  int         pend_n;
  bit         halted, m_ready;

  always #5 clk = ~clk;

  cpu_fetch_decode #(.ADDR_W(14), .FIFO_DEPTH(4), .HLT_STALL(1)) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .FLUSH_I(flush), .RESUME_I(resume),
    .BYTE_I(data), .BYTE_PC_I(pc), .BYTE_VLD_I(vld), .BYTE_RDY_O(byte_rdy),
    .INS_VLD_O(ins_vld), .INS_RDY_I(ins_rdy), .INS_CLASS_O(ins_class),
    .INS_OP_O(ins_op), .INS_IMM_O(ins_imm), .INS_LEN_O(ins_len),
    .INS_PC_O(ins_pc), .FIFO_CNT_O(fifo_cnt)
  );

  function automatic logic [4:0] cls_of(input logic [7:0] b);
    int hi, mid, lo;
    hi = int'(b[7:6]); mid = int'(b[5:3]); lo = int'(b[2:0]);
    if (b <= 8'h01) return 5'd0;
    if (b == 8'hFF) return 5'd1;
    if (hi == 0) begin
      if (lo == 0) return (mid >= 1 && mid <= 6) ? 5'd2 : 5'd22;
      if (lo == 1) return (mid >= 1 && mid <= 6) ? 5'd3 : 5'd22;
      if (lo == 2) return (mid < 4) ? 5'd4 : 5'd22;
      if (lo == 3) return 5'd5;
      if (lo == 4) return 5'd6;
      if (lo == 5) return 5'd7;
      if (lo == 6) return (mid != 7) ? 5'd8 : 5'd9;
      return 5'd10;
    end
    if (hi == 1) begin
      if (lo % 2 == 1) return (mid / 2 == 0) ? 5'd15 : 5'd16;
      return 5'(11 + lo / 2);
    end
    if (hi == 2) return (lo == 7) ? 5'd18 : 5'd17;
    if (mid == 7) return 5'd21;
    return (lo == 7) ? 5'd20 : 5'd19;
  endfunction

  function automatic int len_of(input logic [4:0] c);
    if (c inside {5'd6, 5'd8, 5'd9}) return 2;
    if (c >= 5'd11 && c <= 5'd14) return 3;
    return 1;
  endfunction

  function automatic bit exp_rdy();
    return m_ready && !halted && q.size() < 4 && !flush;
  endfunction

  function automatic ent_t exp_head();
    return (q.size() > 0) ? q[0] : ent_t'('0);
  endfunction

  task automatic model_reset();
    q.delete();
    pend_n  = 0;
    halted  = 0;
    m_ready = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven, then the clock.
  task automatic cycle();
    bit acc, pop;
    logic [4:0] c;
    int l;
    ent_t e;
    acc = vld && exp_rdy();
    pop = (q.size() > 0) && ins_rdy;
    m_ready = 1;
    if (flush) begin
      q.delete();
      pend_n = 0;
      halted = 0;
    end else begin
      if (pop) q.delete(0);
      if (acc) begin
        if (pend_n == 0) pend_pc = pc;
        pend[pend_n] = data;
        pend_n++;
        c = cls_of(pend[0]);
        l = len_of(c);
        if (pend_n == l) begin
          e.cls = c; e.op = pend[0]; e.len = 2'(l); e.pc = pend_pc;
          e.imm = (l == 3) ? {pend[2], pend[1]} : (l == 2) ? {8'h00, pend[1]} : 16'h0000;
          q.push_back(e);
          pend_n = 0;
          if (c == 5'd1) halted = 1;
        end
      end else if (halted && resume) begin
        halted = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; resume = 0; vld = 0; ins_rdy = 0; data = '0; pc = '0;
    model_reset();
    #2;
    checks++;
    if ({byte_rdy, ins_vld, fifo_cnt} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got rdy=%0b vld=%0b cnt=%0d exp 0/0/0", byte_rdy, ins_vld, fifo_cnt);
    end
    checks++;
    if ({ins_class, ins_op, ins_imm, ins_len, ins_pc} !== 45'h0) begin
      failures++; $display("FAIL reset_fields got cls=%0d op=%h imm=%h len=%0d pc=%h exp all 0", ins_class, ins_op, ins_imm, ins_len, ins_pc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (byte_rdy !== 1'b0) begin
      failures++; $display("FAIL reset_release_rdy got=%0b exp=0", byte_rdy);
    end
    cycle();
    checks++;
    if (byte_rdy !== 1'b1) begin
      failures++; $display("FAIL first_edge_rdy got=%0b exp=1", byte_rdy);
    end
  endtask

  task automatic test_jmp();
    vld = 1; data = 8'h44; pc = 14'h100; cycle();
    data = 8'h34; pc = 14'h101; cycle();
    checks++;
    if (ins_vld !== 1'b0) begin
      failures++; $display("FAIL jmp_early_vld got=%0b exp=0", ins_vld);
    end
    data = 8'h12; pc = 14'h102; cycle();
    vld = 0;
    checks++;
    if ({ins_vld, ins_class, ins_len, ins_imm, ins_pc} !== {1'b1, 5'd13, 2'd3, 16'h1234, 14'h100}) begin
      failures++; $display("FAIL jmp_entry got vld=%0b cls=%0d len=%0d imm=%h pc=%h exp 1/13/3/1234/100", ins_vld, ins_class, ins_len, ins_imm, ins_pc);
    end
    ins_rdy = 1; cycle(); ins_rdy = 0;
    checks++;
    if (fifo_cnt !== 3'd0) begin
      failures++; $display("FAIL jmp_pop_cnt got=%0d exp=0", fifo_cnt);
    end
  endtask

  task automatic test_full();
    vld = 1; data = 8'hC1;
    for (int k = 0; k < 4; k++) begin
      pc = 14'(14'h200 + k);
      cycle();
    end
    pc = 14'h204; cycle(); cycle();
    checks++;
    if ({fifo_cnt, byte_rdy} !== {3'd4, 1'b0}) begin
      failures++; $display("FAIL full_hold got cnt=%0d rdy=%0b exp 4/0", fifo_cnt, byte_rdy);
    end
    ins_rdy = 1; cycle(); ins_rdy = 0;
    checks++;
    if ({fifo_cnt, byte_rdy} !== {3'd3, 1'b1}) begin
      failures++; $display("FAIL full_after_pop got cnt=%0d rdy=%0b exp 3/1", fifo_cnt, byte_rdy);
    end
    cycle();
    vld = 0;
    checks++;
    if (fifo_cnt !== 3'd4) begin
      failures++; $display("FAIL full_fifth_cnt got=%0d exp=4", fifo_cnt);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({ins_vld, ins_class, ins_pc} !== {1'b1, 5'd19, 14'(14'h200 + k)}) begin
        failures++; $display("FAIL full_order[%0d] got vld=%0b cls=%0d pc=%h exp 1/19/%h", k, ins_vld, ins_class, ins_pc, 14'h200 + k);
      end
      ins_rdy = 1; cycle(); ins_rdy = 0;
    end
  endtask

  task automatic test_halt();
    vld = 1; data = 8'hFF; pc = 14'h300; cycle();
    data = 8'hC0; pc = 14'h301; cycle(); cycle();
    checks++;
    if ({byte_rdy, fifo_cnt, ins_class} !== {1'b0, 3'd1, 5'd1}) begin
      failures++; $display("FAIL halt_stall got rdy=%0b cnt=%0d cls=%0d exp 0/1/1", byte_rdy, fifo_cnt, ins_class);
    end
    resume = 1; cycle(); resume = 0;
    checks++;
    if ({byte_rdy, fifo_cnt} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL halt_resume got rdy=%0b cnt=%0d exp 1/1", byte_rdy, fifo_cnt);
    end
    cycle();
    vld = 0;
    ins_rdy = 1; cycle(); ins_rdy = 0;
    checks++;
    if ({ins_vld, ins_class, ins_op, ins_pc} !== {1'b1, 5'd19, 8'hC0, 14'h301}) begin
      failures++; $display("FAIL halt_next got vld=%0b cls=%0d op=%h pc=%h exp 1/19/c0/301", ins_vld, ins_class, ins_op, ins_pc);
    end
    ins_rdy = 1; cycle(); ins_rdy = 0;
  endtask

  task automatic test_flush();
    vld = 1; data = 8'h06; pc = 14'h400; cycle();
    vld = 0; flush = 1;
    #1;
    checks++;
    if (byte_rdy !== 1'b0) begin
      failures++; $display("FAIL flush_rdy got=%0b exp=0", byte_rdy);
    end
    cycle(); flush = 0;
    vld = 1; data = 8'h3E; pc = 14'h401; cycle();
    data = 8'h55; pc = 14'h402; cycle();
    vld = 0;
    checks++;
    if ({fifo_cnt, ins_class, ins_op, ins_imm, ins_len, ins_pc} !== {3'd1, 5'd9, 8'h3E, 16'h0055, 2'd2, 14'h401}) begin
      failures++; $display("FAIL flush_lmi got cnt=%0d cls=%0d op=%h imm=%h len=%0d pc=%h exp 1/9/3e/0055/2/401", fifo_cnt, ins_class, ins_op, ins_imm, ins_len, ins_pc);
    end
    ins_rdy = 1; cycle(); ins_rdy = 0;
  endtask

  task automatic test_illegal_and_async_reset();
    logic [7:0] ops [3];
    logic [4:0] cls [3];
    ops = '{8'h3A, 8'h38, 8'h00};
    cls = '{5'd22, 5'd22, 5'd0};
    vld = 1;
    for (int k = 0; k < 3; k++) begin
      data = ops[k]; pc = 14'(14'h500 + k); cycle();
    end
    vld = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ins_class, ins_op, ins_len} !== {cls[k], ops[k], 2'd1}) begin
        failures++; $display("FAIL illegal[%0d] got cls=%0d op=%h len=%0d exp %0d/%h/1", k, ins_class, ins_op, ins_len, cls[k], ops[k]);
      end
      ins_rdy = 1; cycle(); ins_rdy = 0;
    end
    vld = 1; data = 8'h46; pc = 14'h510; cycle();
    data = 8'h00; pc = 14'h511; ins_rdy = 0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({byte_rdy, ins_vld, fifo_cnt, ins_class, ins_op, ins_imm, ins_len, ins_pc} !== 50'h0) begin
      failures++; $display("FAIL async_reset got rdy=%0b vld=%0b cnt=%0d cls=%0d exp all 0", byte_rdy, ins_vld, fifo_cnt, ins_class);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    cycle();
    vld = 0;
    checks++;
    if ({fifo_cnt, ins_class, ins_len, ins_pc} !== {3'd1, 5'd0, 2'd1, 14'h511}) begin
      failures++; $display("FAIL reset_discard got cnt=%0d cls=%0d len=%0d pc=%h exp 1/0/1/511", fifo_cnt, ins_class, ins_len, ins_pc);
    end
    ins_rdy = 1; cycle(); ins_rdy = 0;
  endtask

  task automatic test_random();
    ent_t h;
    for (int i = 0; i < 3000; i++) begin
      vld     = ($urandom_range(3) != 0);
      data    = ($urandom_range(15) == 0) ? 8'hFF : 8'($urandom);
      pc      = 14'($urandom);
      ins_rdy = ($urandom_range(2) != 0);
      flush   = ($urandom_range(40) == 0);
      resume  = ($urandom_range(5) == 0);
      #1;
      h = exp_head();
      checks++;
      if ({byte_rdy, ins_vld, fifo_cnt, ins_class, ins_op, ins_imm, ins_len, ins_pc} !==
          {exp_rdy(), q.size() > 0, 3'(q.size()), h}) begin
        failures++;
        $display("FAIL random[%0d] got rdy=%0b vld=%0b cnt=%0d head=%h exp rdy=%0b vld=%0b cnt=%0d head=%h",
                 i, byte_rdy, ins_vld, fifo_cnt, {ins_class, ins_op, ins_imm, ins_len, ins_pc},
                 exp_rdy(), q.size() > 0, q.size(), h);
      end
      cycle();
    end
    vld = 0; flush = 0; resume = 0; ins_rdy = 0;
  endtask

  initial begin
    test_reset();
    test_jmp();
    test_full();
    test_halt();
    test_flush();
    test_illegal_and_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
